// File: rtl/sha_msg_schedule_if.sv
// Block-in / schedule-word-out bundle of the SHA-2 message scheduler.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// a raised valid holds, with its payload stable, until that transfer (ready may do anything).
interface sha_msg_schedule_if #(parameter int WORD_W = 32);
  logic                   blk_valid;
  logic                   blk_ready;
  logic [16*WORD_W-1:0]   blk_data;
  logic                   w_valid;
  logic                   w_ready;
  logic [WORD_W-1:0]      w_data;
  logic [6:0]             w_index;
  logic                   w_last;
  logic                   busy;
  logic                   state_dbg;

  // Scheduler side.
  modport master (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_index, w_last, busy, state_dbg
  );

  // Block producer / word consumer side.
  modport slave (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_index, w_last, busy, state_dbg
  );
endinterface

// File: rtl/sha_msg_schedule.sv
// SHA-256 / SHA-512 message schedule generator: takes one 16-word block and streams
// W[0..ROUNDS-1] using a 16-entry circular buffer, one word per accepted handshake.
module sha_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    sha_msg_schedule_if.master   bus
);

    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
        $error("sha_msg_schedule: WORD_W/ROUNDS must be 32/64 or 64/80");
    end

    localparam int S0_A = (WORD_W == 64) ? 1  : 7;
    localparam int S0_B = (WORD_W == 64) ? 8  : 18;
    localparam int S0_C = (WORD_W == 64) ? 7  : 3;
    localparam int S1_A = (WORD_W == 64) ? 19 : 17;
    localparam int S1_B = (WORD_W == 64) ? 61 : 19;
    localparam int S1_C = (WORD_W == 64) ? 6  : 10;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [6:0]        t_q;
    logic [WORD_W-1:0] sched_q [16];
    logic              arm_q;
    logic              accept, fire, last_t;
    logic [3:0]        t_lo, i2, i7, i15;
    logic [WORD_W-1:0] w_word, w_new;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
    endfunction

    // arm_q keeps blk_ready low for one cycle after reset release and after each block.
    assign accept = (state_q == IDLE) && arm_q && bus.blk_valid && !clr;
    assign fire   = (state_q == RUN) && bus.w_ready && !clr;
    assign last_t = (t_q == 7'(ROUNDS - 1));

    // Circular-buffer taps: (t-15) mod 16 equals (t+1) mod 16.
    assign t_lo = t_q[3:0];
    assign i2   = t_lo - 4'd2;
    assign i7   = t_lo - 4'd7;
    assign i15  = t_lo + 4'd1;

    always_comb begin
        w_new  = sigma1(sched_q[i2]) + sched_q[i7] + sigma0(sched_q[i15]) + sched_q[t_lo];
        w_word = (t_q < 7'd16) ? sched_q[t_lo] : w_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = RUN;
                RUN:     if (fire && last_t) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.state_dbg = state_q;
        bus.w_valid   = (state_q == RUN);
        bus.blk_ready = (state_q == IDLE) && arm_q;
        bus.w_last    = (state_q == RUN) && last_t;
        bus.w_data    = (state_q == RUN) ? w_word : '0;
        bus.w_index   = (state_q == RUN) ? t_q : 7'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q   <= 7'd0;
            arm_q <= 1'b0;
            for (int i = 0; i < 16; i++) sched_q[i] <= '0;
        end else begin
            arm_q <= (state_q == IDLE) && !accept;
            if (clr) begin
                t_q <= 7'd0;
            end else if (accept) begin
                t_q <= 7'd0;
                for (int i = 0; i < 16; i++) sched_q[i] <= bus.blk_data[(15 - i) * WORD_W +: WORD_W];
            end else if (fire) begin
                // Slot t%16 held W[t-16], which no later word needs.
                if (t_q >= 7'd16) sched_q[t_lo] <= w_word;
                t_q <= last_t ? 7'd0 : t_q + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: SHA-256 and SHA-512 instances, "abc" vectors,
// stalls, clr/rst aborts and back-to-back blocks.
module tb_sha_msg_schedule;

  logic clk = 1'b0;
  logic rst, clr;
  always #5 clk = ~clk;

  sha_msg_schedule_if #(.WORD_W(32)) if32 ();
  sha_msg_schedule_if #(.WORD_W(64)) if64 ();

  logic          sel;
  logic          blk_valid_drv, w_ready_drv;
  logic [1023:0] blk_drv;

  assign if32.blk_valid = blk_valid_drv && !sel;
  assign if64.blk_valid = blk_valid_drv && sel;
  assign if32.blk_data  = blk_drv[511:0];
  assign if64.blk_data  = blk_drv;
  assign if32.w_ready   = w_ready_drv && !sel;
  assign if64.w_ready   = w_ready_drv && sel;

  logic [63:0] o_valid, o_ready, o_busy, o_last, o_index, o_data, o_state;
  assign o_valid = 64'(sel ? if64.w_valid : if32.w_valid);
  assign o_ready = 64'(sel ? if64.blk_ready : if32.blk_ready);
  assign o_busy  = 64'(sel ? if64.busy : if32.busy);
  assign o_last  = 64'(sel ? if64.w_last : if32.w_last);
  assign o_index = 64'(sel ? if64.w_index : if32.w_index);
  assign o_data  = sel ? if64.w_data : 64'(if32.w_data);
  assign o_state = 64'(sel ? if64.state_dbg : if32.state_dbg);

  sha_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .clr(clr), .bus(if32.master)
  );
  sha_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .clr(clr), .bus(if64.master)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_w [80];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mask_of(input int ww);
    return (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input int ww, input logic [63:0] x, input int n);
    logic [63:0] m;
    m = mask_of(ww);
    return (((x & m) >> n) | ((x & m) << (ww - n))) & m;
  endfunction

  function automatic logic [63:0] sig0(input int ww, input logic [63:0] x);
    if (ww == 64) return rotr(64, x, 1) ^ rotr(64, x, 8) ^ (x >> 7);
    return rotr(32, x, 7) ^ rotr(32, x, 18) ^ ((x & mask_of(32)) >> 3);
  endfunction

  function automatic logic [63:0] sig1(input int ww, input logic [63:0] x);
    if (ww == 64) return rotr(64, x, 19) ^ rotr(64, x, 61) ^ (x >> 6);
    return rotr(32, x, 17) ^ rotr(32, x, 19) ^ ((x & mask_of(32)) >> 10);
  endfunction

  // Straight-line reference: full W array, no circular buffer.
  function automatic void gold(input int ww, input int rounds, input logic [1023:0] blk);
    logic [63:0] w [80];
    logic [63:0] m;
    m = mask_of(ww);
    exp_q.delete();
    for (int t = 0; t < rounds; t++) begin
      if (t < 16) w[t] = 64'(blk >> ((15 - t) * ww)) & m;
      else w[t] = (sig1(ww, w[t-2]) + w[t-7] + sig0(ww, w[t-15]) + w[t-16]) & m;
      exp_q.push_back(w[t]);
    end
  endfunction

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic accept_block(input logic [1023:0] blk, input string tag);
    int n = 0;
    while (o_ready[0] !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check({tag, "_blk_ready"}, o_ready, 64'd1);
    blk_drv       = blk;
    blk_valid_drv = 1'b1;
    step();
    blk_valid_drv = 1'b0;
    blk_drv       = rand_blk();
    check({tag, "_lat1_valid"}, o_valid, 64'd1);
    check({tag, "_lat1_index"}, o_index, 64'd0);
  endtask

  // Streams words until rounds are done or w_index reaches stop_at (left un-accepted).
  task automatic collect(input int rounds, input int ready_pct, input string tag, input int stop_at);
    int t = 0;
    int stalls = 0;
    logic [63:0] e;
    while (t < rounds && t != stop_at) begin
      e = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
      check($sformatf("%s_valid_t%0d", tag, t), o_valid, 64'd1);
      check($sformatf("%s_index_t%0d", tag, t), o_index, 64'(t));
      check($sformatf("%s_data_t%0d", tag, t), o_data, e);
      check($sformatf("%s_last_t%0d", tag, t), o_last, 64'(t == rounds - 1));
      check($sformatf("%s_bready_t%0d", tag, t), o_ready, 64'd0);
      obs_w[t] = o_data;
      w_ready_drv = (int'($urandom_range(99)) < ready_pct) || (stalls >= 20);
      step();
      if (w_ready_drv) begin
        t++;
        stalls = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        stalls++;
      end
    end
    w_ready_drv = 1'b0;
  endtask

  task automatic after_last(input string tag);
    check({tag, "_post_valid"}, o_valid, 64'd0);
    check({tag, "_post_busy"},  o_busy,  64'd0);
    check({tag, "_bubble_ready"}, o_ready, 64'd0);
    step();
    check({tag, "_ready_2cyc"}, o_ready, 64'd1);
  endtask

  logic [1023:0] abc32, abc64, b;
  logic [1023:0] blks [3];
  int            n;

  initial begin
    sel = 1'b0; rst = 1'b1; clr = 1'b0;
    blk_valid_drv = 1'b0; w_ready_drv = 1'b0; blk_drv = '0;
    abc32 = '0; abc32[511:480] = 32'h6162_6380; abc32[31:0] = 32'h0000_0018;
    abc64 = '0; abc64[1023:960] = 64'h6162_6380_0000_0000; abc64[63:0] = 64'h18;

    // Reset values and first blk_ready after release.
    step(); step();
    check("rst_blk_ready", o_ready, 64'd0);
    check("rst_w_valid",   o_valid, 64'd0);
    check("rst_busy",      o_busy,  64'd0);
    check("rst_w_data",    o_data,  64'd0);
    check("rst_w_index",   o_index, 64'd0);
    check("rst_w_last",    o_last,  64'd0);
    check("rst_state",     o_state, 64'd0);
    rst = 1'b0;
    #1;
    check("rel_ready_before_edge", o_ready, 64'd0);
    step();
    check("rel_ready_first_edge", o_ready, 64'd1);

    // SHA-256 "abc", no stalls.
    gold(32, 64, abc32);
    accept_block(abc32, "abc32");
    collect(64, 100, "abc32", -1);
    check("abc32_w16", obs_w[16], 64'h6162_6380);
    check("abc32_w17", obs_w[17], 64'h000F_0000);
    after_last("abc32");

    // Random block with ~30% w_ready.
    b = rand_blk();
    gold(32, 64, b);
    accept_block(b, "rnd30");
    collect(64, 30, "rnd30", -1);
    after_last("rnd30");

    // clr at t=20, then a fresh block.
    b = rand_blk();
    gold(32, 64, b);
    accept_block(b, "clr");
    collect(64, 100, "clr_pre", 20);
    check("clr_at_t20", o_index, 64'd20);
    clr = 1'b1; w_ready_drv = 1'b1;
    step();
    clr = 1'b0; w_ready_drv = 1'b0;
    check("clr_valid", o_valid, 64'd0);
    check("clr_busy",  o_busy,  64'd0);
    check("clr_index", o_index, 64'd0);
    step();
    check("clr_valid2", o_valid, 64'd0);
    check("clr_ready",  o_ready, 64'd1);
    b = rand_blk();
    gold(32, 64, b);
    accept_block(b, "clr_new");
    collect(64, 100, "clr_new", -1);
    after_last("clr_new");

    // Asynchronous reset at t=40.
    b = rand_blk();
    gold(32, 64, b);
    accept_block(b, "rst40");
    collect(64, 100, "rst40_pre", 40);
    check("rst40_at_t40", o_index, 64'd40);
    #2;
    rst = 1'b1;
    #1;
    check("rst40_valid", o_valid, 64'd0);
    check("rst40_ready", o_ready, 64'd0);
    check("rst40_busy",  o_busy,  64'd0);
    check("rst40_data",  o_data,  64'd0);
    check("rst40_index", o_index, 64'd0);
    check("rst40_last",  o_last,  64'd0);
    step();
    check("rst40_valid_held", o_valid, 64'd0);
    rst = 1'b0;
    #1;
    check("rst40_ready_before_edge", o_ready, 64'd0);
    step();
    check("rst40_ready_after_edge", o_ready, 64'd1);
    check("rst40_no_word", o_valid, 64'd0);

    // Three back-to-back blocks with blk_valid held high.
    for (int i = 0; i < 3; i++) blks[i] = rand_blk();
    blk_valid_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      blk_drv = blks[k];
      gold(32, 64, blks[k]);
      n = 0;
      while (o_ready[0] !== 1'b1 && n < 10) begin
        check($sformatf("b2b%0d_no_word_in_gap", k), o_valid, 64'd0);
        step();
        n++;
      end
      if (k > 0) check($sformatf("b2b%0d_bubble", k), 64'(n), 64'd1);
      check($sformatf("b2b%0d_ready", k), o_ready, 64'd1);
      step();
      if (k == 2) blk_valid_drv = 1'b0;
      blk_drv = rand_blk();
      check($sformatf("b2b%0d_lat1", k), o_valid, 64'd1);
      collect(64, 100, $sformatf("b2b%0d", k), -1);
    end
    after_last("b2b");

    // SHA-512 "abc" on the 64-bit instance.
    sel = 1'b1;
    #1;
    gold(64, 80, abc64);
    accept_block(abc64, "abc64");
    collect(80, 100, "abc64", -1);
    check("abc64_w16", obs_w[16], 64'h6162_6380_0000_0000);
    check("abc64_w17", obs_w[17], 64'h0003_0000_0000_00C0);
    after_last("abc64");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
